control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the existing `datapath` control inputs.
- Replaces the hand-sequenced T-state stimulus used in the datapath benches.
- Fetches each instruction, decodes `IR[31:27]`, and steps through one micro-step per `Clock` cycle until the instruction completes, then returns to fetch.
- Sits directly upstream of `datapath`: consumes `IR` and `CON_FF`, produces every bus-drive, register-load and memory strobe.

Parameters:
- OPW, 5, opcode field width (`IR[31:27]`).

Ports:
- `Clock` in 1: single system clock, rising-edge.
- `Reset` in 1: asynchronous, active-high.
- `Stop` in 1: halt request, sampled only at the fetch boundary.
- `IR` in 32: instruction register contents from datapath.
- `CON_FF` in 1: branch-condition flip-flop from datapath.
- `PCout Zhighout Zlowout MDRout HIout LOout InPortout Cout BAout` out 1 each: bus drive selects.
- `PCin Zin MDRin MARin Yin HIin LOin IRin OutPortin CONin` out 1 each: register loads.
- `Gra Grb Grc Rin Rout` out 1 each: register-select and general-register strobes.
- `IncPC Read Write` out 1 each: ALU increment and memory strobes.
- `Run` out 1: high while executing, low in HALT.
- `Clear` out 1: datapath clear, high in reset states.

Behaviour:
- **Timing**
  - One state per `Clock` cycle.
  - All outputs are a pure decode of the registered state, plus `CON_FF` in BR_T6 only.
  - Every unlisted output is 0 in every state.
- **Reset**
  - While `Reset`=1: state=RST, all strobes 0, `Clear`=1, `Run`=0.
  - First edge after release: RST→T0, with `Clear` deasserting as the state leaves RST.
  - `Reset` mid-instruction aborts immediately (async). No memory write completes after assertion.
- **Fetch**
  - T0: `PCout` `MARin` `IncPC` `Zin`.
  - T1: `Zlowout` `PCin` `Read` `MDRin`.
  - T2: `MDRout` `IRin`.
  - T2→T3 always. Execute states decode the latched `IR[31:27]`.
- **Opcodes**
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - addi 01100, andi 01101, ori 01110
  - mul 01111, div 10000, br 10010
  - in 10110, out 10111, mfhi 11000, mflo 11001
  - nop 11010, halt 11011
- **Execute sequences**
  - ld/ldi/st, T3 and T4:
    - T3: `Grb` `BAout` `Yin`.
    - T4: `Cout` `Zin`.
  - ldi, T5: `Zlowout` `Gra` `Rin`, done.
  - ld, T5–T7:
    - T5: `Zlowout` `MARin`.
    - T6: `Read` `MDRin`.
    - T7: `MDRout` `Gra` `Rin`.
  - st, T5–T7:
    - T5: `Zlowout` `MARin`.
    - T6: `Gra` `Rout` `MDRin`.
    - T7: `Write`.
  - R-type (add/sub/and/or):
    - T3: `Grb` `Rout` `Yin`.
    - T4: `Grc` `Rout` `Zin`.
    - T5: `Zlowout` `Gra` `Rin`.
  - Immediate (addi/andi/ori):
    - T3: `Grb` `Rout` `Yin`.
    - T4: `Cout` `Zin`.
    - T5: `Zlowout` `Gra` `Rin`.
  - mul/div:
    - T3: `Gra` `Rout` `Yin`.
    - T4: `Grb` `Rout` `Zin`.
    - T5: `Zlowout` `LOin`.
    - T6: `Zhighout` `HIin`.
  - br:
    - T3: `Gra` `Rout` `CONin`.
    - T4: `PCout` `Yin`.
    - T5: `Cout` `Zin`.
    - T6: `Zlowout`, plus `PCin` only if `CON_FF`=1.
  - Single-step ops, T3 only:
    - in: `InPortout` `Gra` `Rin`.
    - out: `Gra` `Rout` `OutPortin`.
    - mfhi: `HIout` `Gra` `Rin`.
    - mflo: `LOout` `Gra` `Rin`.
    - nop: no strobes.
  - halt: T3→HALT.
  - Undefined opcode: executes as nop.
- **Completion**
  - After an instruction's last state, next state is T0.
  - Exception: if `Stop`=1 on that edge, next state is HALT.
- **HALT**
  - All strobes 0, `Run`=0, `Clear`=0.
  - Exits only via `Reset`.
  - `Stop` is ignored mid-instruction.
- **Cycle counts, including fetch**
  - nop/in/out/mfhi/mflo: 4
  - ALU and ldi: 6
  - mul/div and br: 7
  - ld/st: 8
- **Invariants**
  - `Read` and `Write` are never both 1.
  - Never more than one bus driver (`*out`, `Rout`, `BAout`) is 1 at a time.

Decomposition:
- `cpu_pkg` holds:
  - opcode localparams listed above;
  - state encoding (RST, T0–T7, HALT, plus per-class execute states);
  - a packed control-word struct/bit-index constants, shared with datapath benches.
- One natural sub-module, `ctrl_decode`: combinational map from (state, opcode, `CON_FF`) to control word.
- `control_sequencer` keeps only the state register and next-state logic.

Test Plan:
- Reset held 3 cycles, then released:
  - `Clear`=1 and `Run`=0 during reset, all strobes 0;
  - T0 strobes (`PCout` `MARin` `IncPC` `Zin`) on the second cycle after release.
- IR=0x611FFFFD (addi r2,r3,-3):
  - T3 `Grb` `Rout` `Yin`, T4 `Cout` `Zin`, T5 `Zlowout` `Gra` `Rin`;
  - T0 again on cycle 7; exactly 6 cycles per instruction.
- IR=0x00800075 (ld R1,$75):
  - `Read` in T1 and T6 only, `MARin` in T0 and T5;
  - `MDRout` `Gra` `Rin` in T7; 8 cycles total.
- IR=0x10800075 (st), checking `Write`:
  - `Write`=1 only in T7; `Read`=0 in T3–T7.
- br with `CON_FF`=0 vs 1 in T6:
  - `PCin`=0 vs 1 respectively;
  - `Zlowout`=1 in T6 in both cases.
- `Stop` raised mid-add:
  - instruction completes through T5, then HALT with `Run`=0.
- halt opcode 11011: HALT after T3.
- `Reset` asserted during ld T6: immediate RST with `Read`=0, and no `Write`.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, sequencer states and control word shared with datapath benches
package cpu_pkg;

   localparam int OPW = 5;

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_BR   = 5'b10010;
   localparam logic [OPW-1:0] OP_IN   = 5'b10110;
   localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
   localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
   localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   // Execute steps are contiguous so the sequencer can simply count T3..T7.
   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef struct packed {
      logic pc_out, z_high_out, z_low_out, mdr_out, hi_out, lo_out, in_port_out, c_out, ba_out;
      logic pc_in, z_in, mdr_in, mar_in, y_in, hi_in, lo_in, ir_in, out_port_in, con_in;
      logic gra, grb, grc, r_in, r_out;
      logic inc_pc, read, write, run, clear;
   } ctrl_word_t;

   function automatic state_t last_step(input logic [OPW-1:0] op);
      case (op)
         OP_LD, OP_ST:                        return S_T7;
         OP_MUL, OP_DIV, OP_BR:               return S_T6;
         OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ADDI, OP_ANDI, OP_ORI:            return S_T5;
         default:                             return S_T3;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational map from sequencer state and opcode to control word
module ctrl_decode
   import cpu_pkg::*;
(
   input  state_t               state,
   input  logic [OPW-1:0]       opcode,
   input  logic                 con_ff,
   output ctrl_word_t           cw
);

   always_comb begin
      cw = '0;
      cw.run = (state != S_RST) && (state != S_HALT);
      case (state)
         S_RST: cw.clear = 1'b1;
         S_T0: begin cw.pc_out = 1'b1; cw.mar_in = 1'b1; cw.inc_pc = 1'b1; cw.z_in = 1'b1; end
         S_T1: begin cw.z_low_out = 1'b1; cw.pc_in = 1'b1; cw.read = 1'b1; cw.mdr_in = 1'b1; end
         S_T2: begin cw.mdr_out = 1'b1; cw.ir_in = 1'b1; end
         S_T3: begin
            case (opcode)
               OP_LD, OP_LDI, OP_ST: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1; end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:
                  begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
               OP_MUL, OP_DIV: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
               OP_BR:   begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.con_in = 1'b1; end
               OP_IN:   begin cw.in_port_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               OP_OUT:  begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.out_port_in = 1'b1; end
               OP_MFHI: begin cw.hi_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               OP_MFLO: begin cw.lo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (opcode)
               OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: begin cw.c_out = 1'b1; cw.z_in = 1'b1; end
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin cw.grc = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; end
               OP_MUL, OP_DIV: begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; end
               OP_BR:   begin cw.pc_out = 1'b1; cw.y_in = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (opcode)
               OP_LD, OP_ST: begin cw.z_low_out = 1'b1; cw.mar_in = 1'b1; end
               OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:
                  begin cw.z_low_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               OP_MUL, OP_DIV: begin cw.z_low_out = 1'b1; cw.lo_in = 1'b1; end
               OP_BR:   begin cw.c_out = 1'b1; cw.z_in = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (opcode)
               OP_LD:   begin cw.read = 1'b1; cw.mdr_in = 1'b1; end
               OP_ST:   begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.mdr_in = 1'b1; end
               OP_MUL, OP_DIV: begin cw.z_high_out = 1'b1; cw.hi_in = 1'b1; end
               OP_BR:   begin cw.z_low_out = 1'b1; cw.pc_in = con_ff; end
               default: ;
            endcase
         end
         S_T7: begin
            case (opcode)
               OP_LD:   begin cw.mdr_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               OP_ST:   cw.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer driving the datapath controls
module control_sequencer #(
   parameter int OPW = 5
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stop,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
   output logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin,
   output logic        Gra, Grb, Grc, Rin, Rout,
   output logic        IncPC, Read, Write,
   output logic        Run,
   output logic        Clear
);
   import cpu_pkg::*;

   state_t         state;
   ctrl_word_t     cw;
   logic [OPW-1:0] opcode;
   logic           unused_ir;

   assign opcode    = IR[31 -: OPW];
   assign unused_ir = ^IR[31-OPW:0];

   // Stop is only honoured on the edge that would otherwise return to fetch.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= S_RST;
      end else begin
         case (state)
            S_RST:  state <= S_T0;
            S_T0:   state <= S_T1;
            S_T1:   state <= S_T2;
            S_T2:   state <= S_T3;
            S_HALT: state <= S_HALT;
            default: begin
               if (state == S_T3 && opcode == OP_HALT)
                  state <= S_HALT;
               else if (state == last_step(opcode))
                  state <= Stop ? S_HALT : S_T0;
               else
                  state <= state_t'(state + 4'd1);
            end
         endcase
      end
   end

   ctrl_decode u_decode (
      .state  (state),
      .opcode (opcode),
      .con_ff (CON_FF),
      .cw     (cw)
   );

   assign PCout     = cw.pc_out;
   assign Zhighout  = cw.z_high_out;
   assign Zlowout   = cw.z_low_out;
   assign MDRout    = cw.mdr_out;
   assign HIout     = cw.hi_out;
   assign LOout     = cw.lo_out;
   assign InPortout = cw.in_port_out;
   assign Cout      = cw.c_out;
   assign BAout     = cw.ba_out;
   assign PCin      = cw.pc_in;
   assign Zin       = cw.z_in;
   assign MDRin     = cw.mdr_in;
   assign MARin     = cw.mar_in;
   assign Yin       = cw.y_in;
   assign HIin      = cw.hi_in;
   assign LOin      = cw.lo_in;
   assign IRin      = cw.ir_in;
   assign OutPortin = cw.out_port_in;
   assign CONin     = cw.con_in;
   assign Gra       = cw.gra;
   assign Grb       = cw.grb;
   assign Grc       = cw.grc;
   assign Rin       = cw.r_in;
   assign Rout      = cw.r_out;
   assign IncPC     = cw.inc_pc;
   assign Read      = cw.read;
   assign Write     = cw.write;
   assign Run       = cw.run;
   assign Clear     = cw.clear;

endmodule
